// File: rtl/hdmi_pattern_sequencer_pkg.sv
// Shared constants for the HDMI test-pattern sequencer: pattern codes,
// colour-bar palette and sequencer state encoding.
package hdmi_pattern_pkg;

    localparam logic [1:0] PAT_GRADIENT = 2'd0;
    localparam logic [1:0] PAT_BARS     = 2'd1;
    localparam logic [1:0] PAT_CHECKER  = 2'd2;
    localparam logic [1:0] PAT_SOLID    = 2'd3;

    // Entry i is the bar colour for cx[6:4] == i (entry 0 sits in the low bits).
    localparam logic [7:0][23:0] BAR_COLORS = {
        24'h999999, 24'hffffff, 24'h00ffff, 24'hff00ff,
        24'hffff00, 24'hff0000, 24'h00ff00, 24'h0000ff
    };

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_PENDING = 1'b1
    } seq_state_t;

endpackage

// File: rtl/hdmi_pattern_sequencer_if.sv
// Pattern-change request channel between board logic and the sequencer.
interface hdmi_pattern_sequencer_if;

    logic       mode_req_valid;
    logic [1:0] mode_req_pattern;
    logic       mode_req_ready;

    modport master (output mode_req_valid, output mode_req_pattern, input mode_req_ready);
    modport slave  (input mode_req_valid, input mode_req_pattern, output mode_req_ready);

endinterface

// File: rtl/hdmi_pattern_sequencer_pattern_generator.sv
// Combinational pixel source: maps scan position + pattern to a colour,
// forcing black outside the active area.
module pattern_generator
    import hdmi_pattern_pkg::*;
#(
    parameter int BIT_WIDTH     = 10,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480
) (
    input  logic [BIT_WIDTH-1:0] cx,
    input  logic [BIT_WIDTH-1:0] cy,
    input  logic [1:0]           pattern,
    input  logic [23:0]          solid_color,
    output logic [23:0]          pixel
);

    // Gradient always packs 10-bit coordinates regardless of counter width.
    logic [9:0] cx10;
    logic [9:0] cy10;
    logic       blank;

    assign cx10  = 10'(cx);
    assign cy10  = 10'(cy);
    assign blank = (cx >= BIT_WIDTH'(SCREEN_WIDTH)) || (cy >= BIT_WIDTH'(SCREEN_HEIGHT));

    // Pattern select with blanking override.
    always_comb begin
        pixel = 24'h000000;
        if (!blank) begin
            case (pattern)
                PAT_GRADIENT: pixel = {cx10, cy10, 4'd0};
                PAT_BARS:     pixel = BAR_COLORS[cx[6:4]];
                PAT_CHECKER:  pixel = (cx[4] ^ cy[4]) ? 24'hffffff : 24'h000000;
                PAT_SOLID:    pixel = solid_color;
                default:      pixel = 24'h000000;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_pattern_sequencer.sv
// Drives the hdmi core's rgb input: picks one of four test patterns and
// only switches pattern on a frame boundary (auto-advance or request).
module hdmi_pattern_sequencer
    import hdmi_pattern_pkg::*;
#(
    parameter int BIT_WIDTH          = 10,
    parameter int SCREEN_WIDTH       = 640,
    parameter int SCREEN_HEIGHT      = 480,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic [BIT_WIDTH-1:0]  cx,
    input  logic [BIT_WIDTH-1:0]  cy,
    input  logic                  auto_enable,
    hdmi_pattern_sequencer_if.slave mode_req,
    input  logic [23:0]           solid_rgb,
    output logic [23:0]           rgb,
    output logic [1:0]            pattern,
    output logic                  frame_start
);

    localparam logic [7:0] CNT_LAST = 8'(FRAMES_PER_PATTERN - 1);

    seq_state_t  state, state_nxt;
    logic        fs;
    logic [1:0]  pattern_nxt;
    logic [1:0]  pending, pending_nxt;
    logic [7:0]  frame_cnt, cnt_nxt;
    logic [23:0] solid_latch;
    logic [23:0] solid_cur;
    logic [23:0] pixel;

    assign fs                      = (cx == '0) && (cy == '0);
    assign mode_req.mode_req_ready = (state == ST_RUN);

    // Next-state: frame-count auto-advance in RUN, apply latched request in PENDING.
    always_comb begin
        state_nxt   = state;
        pattern_nxt = pattern;
        cnt_nxt     = frame_cnt;
        pending_nxt = pending;
        case (state)
            ST_RUN: begin
                // A request arriving on fs still lets that fs auto-advance.
                if (fs && auto_enable) begin
                    if (frame_cnt == CNT_LAST) begin
                        pattern_nxt = pattern + 2'd1;
                        cnt_nxt     = '0;
                    end else begin
                        cnt_nxt = frame_cnt + 8'd1;
                    end
                end
                if (mode_req.mode_req_valid) begin
                    pending_nxt = mode_req.mode_req_pattern;
                    state_nxt   = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (fs) begin
                    pattern_nxt = pending;
                    cnt_nxt     = '0;
                    state_nxt   = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            pattern   <= PAT_GRADIENT;
            frame_cnt <= '0;
            pending   <= PAT_GRADIENT;
        end else begin
            state     <= state_nxt;
            pattern   <= pattern_nxt;
            frame_cnt <= cnt_nxt;
            pending   <= pending_nxt;
        end
    end

    // The first pixel of a frame already sees the new solid colour.
    assign solid_cur = fs ? solid_rgb : solid_latch;

    pattern_generator #(
        .BIT_WIDTH     (BIT_WIDTH),
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT)
    ) u_gen (
        .cx          (cx),
        .cy          (cy),
        .pattern     (pattern_nxt),
        .solid_color (solid_cur),
        .pixel       (pixel)
    );

    // Registered pixel output, frame marker and per-frame solid colour capture.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            rgb         <= 24'h000000;
            frame_start <= 1'b0;
            solid_latch <= 24'h000000;
        end else begin
            rgb         <= pixel;
            frame_start <= fs;
            if (fs) solid_latch <= solid_rgb;
        end
    end

endmodule
